// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device emulator.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        GAP  = 3'd4
    } ps2_state_t;

    // Device-to-host frame, bit 0 sent first: start 0, data LSB first, odd parity, stop 1.
    // A high inject flips the parity bit so hosts can exercise their error path.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b, input logic inject);
        return {1'b1, (~^b) ^ inject, b, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with registered level and ready; synchronous active-low reset.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_wdata,
    output logic [7:0]               o_rdata_c,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_ready
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             r_ready;
    logic [LVL_W-1:0] w_count_nxt;
    logic             w_push;
    logic             w_pop;

    // A push needs the registered ready, so a same-cycle pop never lets a full FIFO accept.
    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && (r_count != '0);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + LVL_W'(1);
            2'b01:   w_count_nxt = r_count - LVL_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, level and ready.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != LVL_W'(DEPTH));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_level   = r_count;
    assign o_ready   = r_ready;

endmodule

// File: rtl/ps2_device_model.sv
// PS/2 device emulator: buffers scancode bytes and serialises them as
// 11-bit device-to-host frames on ps2_clk_o/ps2_data_o.
// Optional: define PS2_DEVICE_MODEL_PARITY_INJECT_EN to add parity_err_i,
// which inverts the parity bit of the frame loaded while it is high.
module ps2_device_model #(
    parameter int unsigned CLK_HALF_CYCLES = 5000,
    parameter int unsigned GAP_CYCLES      = 10000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [7:0]                    byte_i,
    input  logic                          byte_valid_i,
`ifdef PS2_DEVICE_MODEL_PARITY_INJECT_EN
    input  logic                          parity_err_i,
`endif
    output logic                          byte_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          ps2_clk_o,
    output logic                          ps2_data_o
);

    import ps2_pkg::*;

    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned MAX_CYC = (CLK_HALF_CYCLES > GAP_CYCLES) ? CLK_HALF_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned BIT_W   = $clog2(PS2_FRAME_BITS);

    ps2_state_t                r_state;
    ps2_state_t                w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [BIT_W-1:0]          r_bit;
    logic [BIT_W-1:0]          w_bit_nxt;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic [PS2_FRAME_BITS-1:0] w_shift_nxt;
    logic                      r_ps2_clk;
    logic                      r_ps2_data;
    logic                      r_busy;
    logic                      w_ps2_clk_nxt;
    logic                      w_ps2_data_nxt;
    logic                      w_busy_nxt;

    logic [7:0]                w_fifo_rdata;
    logic [LVL_W-1:0]          w_fifo_level;
    logic                      w_fifo_ready;
    logic                      w_fifo_empty;
    logic                      w_pop;
    logic                      w_inject;
    logic                      w_half_done;
    logic                      w_gap_done;

`ifdef PS2_DEVICE_MODEL_PARITY_INJECT_EN
    assign w_inject = parity_err_i;
`else
    assign w_inject = 1'b0;
`endif

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk_i),
        .i_rst_n   (reset_n_i),
        .i_push    (byte_valid_i),
        .i_pop     (w_pop),
        .i_wdata   (byte_i),
        .o_rdata_c (w_fifo_rdata),
        .o_level   (w_fifo_level),
        .o_ready   (w_fifo_ready)
    );

    assign w_pop        = (r_state == LOAD);
    assign w_fifo_empty = (w_fifo_level == '0);
    assign w_half_done  = (r_cnt == CNT_W'(CLK_HALF_CYCLES - 1));
    assign w_gap_done   = (r_cnt == CNT_W'(GAP_CYCLES - 1));

    // Next-state, counters and frame shifter; line levels follow the next state so they are registered with it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_fifo_empty) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_cnt_nxt   = '0;
                w_shift_nxt = ps2_frame(w_fifo_rdata, w_inject);
                w_bit_nxt   = '0;
                w_state_nxt = HIGH;
            end
            HIGH: begin
                if (w_half_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (w_half_done) begin
                    w_cnt_nxt = '0;
                    if (r_bit == BIT_W'(PS2_FRAME_BITS - 1)) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_shift_nxt = {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_state_nxt = HIGH;
                    end
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase

        w_ps2_clk_nxt  = (w_state_nxt != LOW);
        w_ps2_data_nxt = ((w_state_nxt == HIGH) || (w_state_nxt == LOW)) ? w_shift_nxt[0] : 1'b1;
        w_busy_nxt     = (w_state_nxt != IDLE);
    end

    // State and output registers; reset discards any frame in flight and idles the lines high.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_ps2_clk  <= w_ps2_clk_nxt;
            r_ps2_data <= w_ps2_data_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign byte_ready_o = w_fifo_ready;
    assign level_o      = w_fifo_level;
    assign busy_o       = r_busy;
    assign ps2_clk_o    = r_ps2_clk;
    assign ps2_data_o   = r_ps2_data;

endmodule
